// File: rtl/output_buffer.sv
// Transmit-side scan buffer: captures a full block in one cycle, then serializes it
// as NUM_CHUNKS chunks over a valid/ready scan bus, chunk 0 (the LSBs) first.
module output_buffer #(
  parameter int CHUNK_W    = 136,
  parameter int NUM_CHUNKS = 8,
  parameter int IDX_W      = 3
) (
  input  logic                          scan_clk,
  input  logic                          rst,
  input  logic [CHUNK_W*NUM_CHUNKS-1:0] block,
  input  logic                          load,
  output logic                          load_ready,
  output logic [CHUNK_W-1:0]            scan_out,
  output logic                          scan_valid,
  input  logic                          scan_ready,
  output logic [IDX_W-1:0]              chunk_idx,
  output logic                          done
);

  localparam int              BLK_W    = CHUNK_W * NUM_CHUNKS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  // state  | meaning
  // S_IDLE | waiting for a load; shreg is all-zero after a completed block
  // S_SEND | presenting shreg[CHUNK_W-1:0] until all chunks are accepted
  typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;

  state_t             r_state;
  logic [BLK_W-1:0]   r_shreg;
  logic [IDX_W-1:0]   r_count;
  logic               r_load_ready;
  logic               r_scan_valid;
  logic               r_done;

  always_ff @(posedge scan_clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_count      <= '0;
      r_load_ready <= 1'b1;
      r_scan_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shreg      <= block;
            r_count      <= '0;
            r_load_ready <= 1'b0;
            r_scan_valid <= 1'b1;
            r_state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (scan_ready) begin
            // zero fill leaves the register clear once the last chunk goes out
            r_shreg <= {{CHUNK_W{1'b0}}, r_shreg[BLK_W-1:CHUNK_W]};
            if (r_count == LAST_IDX) begin
              r_count      <= '0;
              r_load_ready <= 1'b1;
              r_scan_valid <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_count <= r_count + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_load_ready <= 1'b1;
          r_scan_valid <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = r_load_ready;
  assign scan_valid = r_scan_valid;
  assign scan_out   = r_shreg[CHUNK_W-1:0];
  assign chunk_idx  = r_count;
  assign done       = r_done;

endmodule
